immediate_extender: RTL and testbench
=====================================

// Module: immediate_extender
// PURPOSE
//  Pipelined immediate generator that replaces the fixed sign extender in the decode stage.
//  - Takes a raw immediate field and a run-time sign-bit position.
//  - Produces a full-width operand in one of four modes: zero-extend, sign-extend,
//    sign-extend-and-shift (branch offset), upper-immediate.
//  - Sits between instruction decode and the operand mux, behind a valid/ready handshake.
//  - A 2-entry skid buffer sustains 1 transfer/cycle with a registered IN_READY.
// PARAMETERS
//  INPUTSize   16  width of raw immediate field IN_DATA
//  OUTPUTSize  32  width of produced operand OUT_DATA (must be >= INPUTSize)
//  SHIFT_AMT    2  left shift applied in MODE 2'b10 (0 <= SHIFT_AMT < OUTPUTSize)
//  POSW        $clog2(INPUTSize)  width of SIGN_POS (derived, not overridden)
// PORTS
//  CLK        in   1           clock, rising edge
//  RESET_N    in   1           asynchronous active-low reset
//  IN_VALID   in   1           IN_DATA/SIGN_POS/MODE valid
//  IN_READY   out  1           block can accept an input this cycle
//  IN_DATA    in   INPUTSize   raw immediate
//  SIGN_POS   in   POSW        bit index of the field's MSB (field width = SIGN_POS+1)
//  MODE       in   2           00 zero-ext, 01 sign-ext, 10 sign-ext<<SHIFT_AMT, 11 upper
//  OUT_VALID  out  1           OUT_DATA valid
//  OUT_READY  in   1           consumer accepts OUT_DATA this cycle
//  OUT_DATA   out  OUTPUTSize  extended operand
// BEHAVIOUR
//  Reset (RESET_N low, async): buffer EMPTY, OUT_VALID=0, OUT_DATA=0, IN_READY=0.
//    IN_READY rises on the first CLK edge after RESET_N deassertion.
//  Transfers: input on IN_VALID&IN_READY at a CLK edge; output on OUT_VALID&OUT_READY.
//  Arithmetic, combinational on the input side, result stored in the buffer slot:
//    p = min(SIGN_POS, INPUTSize-1); f = IN_DATA[p:0].
//    00: OUT = f zero-extended to OUTPUTSize. Bits of IN_DATA above p are ignored.
//    01: OUT = f sign-extended from bit p.
//    10: OUT = (f sign-extended from bit p) << SHIFT_AMT, truncated to OUTPUTSize.
//        Bits shifted out are discarded; zeros are shifted in.
//    11: OUT = {IN_DATA, (OUTPUTSize-INPUTSize) zeros}. SIGN_POS is ignored.
//  Latency: accepted input appears on OUT_DATA with OUT_VALID=1 on the next edge.
//  States (occupancy):
//    EMPTY: OUT_VALID=0, IN_READY=1.
//      - Input accepted -> ONE.
//    ONE:   OUT_VALID=1, IN_READY=1.
//      - Input accepted and output taken  -> ONE (new data on OUT).
//      - Input accepted, output not taken -> TWO (new data into skid slot).
//      - Output taken, no input           -> EMPTY.
//    TWO:   OUT_VALID=1, IN_READY=0.
//      - Output taken -> ONE; skid entry moves to OUT.
//  Holding rule: OUT_DATA is stable while OUT_VALID=1 and OUT_READY=0.
//  Ordering: strict FIFO. No entry is dropped or duplicated.
//  Ignored inputs:
//    - IN_VALID while IN_READY=0 is ignored; the producer must hold.
//    - OUT_READY while OUT_VALID=0 has no effect.
//  IN_READY is a registered output (no combinational path from OUT_READY).
//  Reset mid-operation: all held entries are discarded immediately; outputs take reset values.
// TESTING (INPUTSize=16, OUTPUTSize=32, SHIFT_AMT=2, OUT_READY=1 unless stated)
//  1. IN_DATA=16'h8001, SIGN_POS=15, MODE=01 -> next cycle OUT_DATA=32'hFFFF8001, OUT_VALID=1.
//  2. IN_DATA=16'hFFF0, SIGN_POS=4:
//       MODE=00 -> 32'h00000010;  MODE=01 -> 32'hFFFFFFF0.
//  3. IN_DATA=16'hFFFF, SIGN_POS=15, MODE=10 -> 32'hFFFFFFFC.
//     IN_DATA=16'h4000, SIGN_POS=15, MODE=10 -> 32'h00010000.
//  4. IN_DATA=16'h1234, MODE=11, SIGN_POS=3 -> 32'h12340000 (SIGN_POS ignored).
//  5. OUT_READY=0; back-to-back inputs A=1,B=2,C=3 (MODE=00, SIGN_POS=15):
//       - A and B accepted; IN_READY=0 on the cycle after B; C held by the producer.
//       - OUT_DATA stays 1.
//       - OUT_READY=1 -> outputs 1,2,3 on consecutive cycles, then OUT_VALID=0.
//  6. Buffer in TWO, RESET_N pulsed low between edges:
//       - OUT_VALID=0, OUT_DATA=0, IN_READY=0 before the next edge.
//       - After release, no stale data appears; IN_READY=1 after one edge.

Source files
------------

// File: rtl/immediate_extender.sv
// Pipelined immediate generator: zero/sign/shifted-sign/upper extension of a raw field
// whose MSB position is chosen at run time, behind a 2-entry skid buffer with registered IN_READY.
module immediate_extender #(
  parameter int INPUTSize  = 16,
  parameter int OUTPUTSize = 32,
  parameter int SHIFT_AMT  = 2,
  localparam int POSW      = $clog2(INPUTSize)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [INPUTSize-1:0]  IN_DATA,
  input  logic [POSW-1:0]       SIGN_POS,
  input  logic [1:0]            MODE,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [OUTPUTSize-1:0] OUT_DATA
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } occ_t;

  // Ones on bits [p:0]; a SIGN_POS beyond the field shifts everything out, which clamps p to the MSB.
  logic [INPUTSize-1:0]  field_mask;
  logic [INPUTSize-1:0]  sign_onehot;
  logic                  sign_bit;
  logic [OUTPUTSize-1:0] zext;
  logic [OUTPUTSize-1:0] sext;
  logic [OUTPUTSize-1:0] shifted;
  logic [OUTPUTSize-1:0] upper;
  logic [OUTPUTSize-1:0] ext_data;

  assign field_mask  = ~(({INPUTSize{1'b1}} << SIGN_POS) << 1);
  assign sign_onehot = field_mask ^ (field_mask >> 1);
  assign sign_bit    = |(IN_DATA & sign_onehot);

  genvar gi;
  generate
    for (gi = 0; gi < OUTPUTSize; gi++) begin : g_ext
      if (gi < INPUTSize) begin : g_field
        assign zext[gi] = IN_DATA[gi] & field_mask[gi];
        assign sext[gi] = field_mask[gi] ? IN_DATA[gi] : sign_bit;
      end else begin : g_above
        assign zext[gi] = 1'b0;
        assign sext[gi] = sign_bit;
      end
    end
  endgenerate

  assign shifted = sext << SHIFT_AMT;
  assign upper   = OUTPUTSize'(IN_DATA) << (OUTPUTSize - INPUTSize);

  always_comb begin
    ext_data = zext;
    case (MODE)
      2'b00:   ext_data = zext;
      2'b01:   ext_data = sext;
      2'b10:   ext_data = shifted;
      default: ext_data = upper;
    endcase
  end

  occ_t                  state_reg, state_next;
  logic [OUTPUTSize-1:0] out_data_reg, out_data_next;
  logic [OUTPUTSize-1:0] skid_reg, skid_next;
  logic                  in_ready_reg;
  logic                  in_fire;
  logic                  out_fire;

  assign IN_READY  = in_ready_reg;
  assign OUT_VALID = (state_reg != ST_EMPTY);
  assign OUT_DATA  = out_data_reg;
  assign in_fire   = IN_VALID & in_ready_reg;
  assign out_fire  = OUT_VALID & OUT_READY;

  always_comb begin
    state_next    = state_reg;
    out_data_next = out_data_reg;
    skid_next     = skid_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (in_fire) begin
          state_next    = ST_ONE;
          out_data_next = ext_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          out_data_next = ext_data;
        end else if (in_fire) begin
          state_next = ST_TWO;
          skid_next  = ext_data;
        end else if (out_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          state_next    = ST_ONE;
          out_data_next = skid_reg;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // IN_READY is computed from next occupancy so it stays a plain flop output.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= ST_EMPTY;
      out_data_reg <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      out_data_reg <= out_data_next;
      skid_reg     <= skid_next;
      in_ready_reg <= (state_next != ST_TWO);
    end
  end

endmodule

// File: tb/tb_immediate_extender.sv
// Self-checking bench for immediate_extender: directed vectors plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_immediate_extender;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] IN_DATA = '0;
  logic [3:0]  SIGN_POS = '0;
  logic [1:0]  MODE = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [31:0] OUT_DATA;

  int total = 0;
  int bad   = 0;

  immediate_extender #(.INPUTSize(16), .OUTPUTSize(32), .SHIFT_AMT(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .SIGN_POS(SIGN_POS), .MODE(MODE), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference arithmetic straight from the field/extension rules.
  function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [3:0] sp, input logic [1:0] m);
    int p;
    longint unsigned span;
    longint f, s;
    p    = (int'(sp) > 15) ? 15 : int'(sp);
    span = 64'd1 << (p + 1);
    f    = longint'(d) & longint'(span - 64'd1);
    s    = d[p] ? f - longint'(span) : f;
    case (m)
      2'b00:   return 32'(f);
      2'b01:   return 32'(s);
      2'b10:   return 32'(s * 4);
      default: return {d, 16'h0000};
    endcase
  endfunction

  // Model: queue of pending outputs, ready flag that comes up one edge after reset release.
  logic [31:0] q[$];
  bit          ready_flag = 0;
  bit          data_zero  = 1;
  bit          in_fire_s  = 0;
  bit          out_fire_s = 0;
  logic [31:0] new_item;

  always @(negedge RESET_N) begin
    q.delete();
    ready_flag = 0;
    data_zero  = 1;
    in_fire_s  = 0;
    out_fire_s = 0;
  end

  always @(negedge CLK) begin
    bit exp_ready, exp_valid;
    if (!RESET_N) begin
      chk(IN_READY == 1'b0, "rst_in_ready", 32'(IN_READY), 32'd0);
      chk(OUT_VALID == 1'b0, "rst_out_valid", 32'(OUT_VALID), 32'd0);
      chk(OUT_DATA == 32'd0, "rst_out_data", OUT_DATA, 32'd0);
      in_fire_s  = 0;
      out_fire_s = 0;
    end else begin
      exp_ready = ready_flag && (q.size() < 2);
      exp_valid = (q.size() > 0);
      chk(IN_READY == exp_ready, "in_ready", 32'(IN_READY), 32'(exp_ready));
      chk(OUT_VALID == exp_valid, "out_valid", 32'(OUT_VALID), 32'(exp_valid));
      if (exp_valid)
        chk(OUT_DATA == q[0], "out_data", OUT_DATA, q[0]);
      else if (data_zero)
        chk(OUT_DATA == 32'd0, "idle_out_data", OUT_DATA, 32'd0);
      in_fire_s  = IN_VALID && exp_ready;
      out_fire_s = exp_valid && OUT_READY;
      if (in_fire_s) new_item = ref_ext(IN_DATA, SIGN_POS, MODE);
    end
  end

  always @(posedge CLK) begin
    if (RESET_N) begin
      if (out_fire_s) void'(q.pop_front());
      if (in_fire_s) begin
        q.push_back(new_item);
        data_zero = 0;
      end
      in_fire_s  = 0;
      out_fire_s = 0;
      ready_flag = 1;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [3:0] sp, input logic [1:0] m);
    int n;
    IN_DATA  = d;
    SIGN_POS = sp;
    MODE     = m;
    IN_VALID = 1'b1;
    n = 0;
    forever begin
      @(negedge CLK);
      if (IN_READY) break;
      n++;
      if (n > 100) begin
        chk(1'b0, "send_timeout", 32'(IN_READY), 32'd1);
        break;
      end
    end
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
  endtask

  task automatic chk_out(input logic [31:0] req, input string name);
    @(negedge CLK);
    chk(OUT_VALID == 1'b1, {name, "_valid"}, 32'(OUT_VALID), 32'd1);
    chk(OUT_DATA == req, name, OUT_DATA, req);
  endtask

  task automatic align;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit accepted;
    #2 RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1 RESET_N = 1'b1;
    #1 chk(IN_READY == 1'b0, "ready_before_edge", 32'(IN_READY), 32'd0);

    chk(ref_ext(16'h8001, 4'd15, 2'b01) == 32'hFFFF8001, "model_sext", ref_ext(16'h8001, 4'd15, 2'b01), 32'hFFFF8001);
    chk(ref_ext(16'hFFF0, 4'd4, 2'b00) == 32'h00000010, "model_zext", ref_ext(16'hFFF0, 4'd4, 2'b00), 32'h00000010);
    chk(ref_ext(16'hFFF0, 4'd4, 2'b01) == 32'hFFFFFFF0, "model_sext4", ref_ext(16'hFFF0, 4'd4, 2'b01), 32'hFFFFFFF0);
    chk(ref_ext(16'hFFFF, 4'd15, 2'b10) == 32'hFFFFFFFC, "model_shift", ref_ext(16'hFFFF, 4'd15, 2'b10), 32'hFFFFFFFC);
    chk(ref_ext(16'h4000, 4'd15, 2'b10) == 32'h00010000, "model_shift_pos", ref_ext(16'h4000, 4'd15, 2'b10), 32'h00010000);
    chk(ref_ext(16'h1234, 4'd3, 2'b11) == 32'h12340000, "model_upper", ref_ext(16'h1234, 4'd3, 2'b11), 32'h12340000);
    chk(ref_ext(16'h0005, 4'd2, 2'b01) == 32'hFFFFFFFD, "model_sext2", ref_ext(16'h0005, 4'd2, 2'b01), 32'hFFFFFFFD);
    chk(ref_ext(16'h0005, 4'd2, 2'b10) == 32'hFFFFFFF4, "model_shift2", ref_ext(16'h0005, 4'd2, 2'b10), 32'hFFFFFFF4);

    align();
    send(16'h8001, 4'd15, 2'b01); chk_out(32'hFFFF8001, "t1"); align();
    send(16'hFFF0, 4'd4, 2'b00);  chk_out(32'h00000010, "t2_zext"); align();
    send(16'hFFF0, 4'd4, 2'b01);  chk_out(32'hFFFFFFF0, "t2_sext"); align();
    send(16'hFFFF, 4'd15, 2'b10); chk_out(32'hFFFFFFFC, "t3_neg"); align();
    send(16'h4000, 4'd15, 2'b10); chk_out(32'h00010000, "t3_pos"); align();
    send(16'h1234, 4'd3, 2'b11);  chk_out(32'h12340000, "t4_upper"); align();

    // Stall the consumer, fill both slots, and hold the third word.
    OUT_READY = 1'b0;
    send(16'd1, 4'd15, 2'b00);
    send(16'd2, 4'd15, 2'b00);
    IN_DATA  = 16'd3;
    IN_VALID = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk(IN_READY == 1'b0, "t5_full_ready", 32'(IN_READY), 32'd0);
      chk(OUT_DATA == 32'd1, "t5_hold", OUT_DATA, 32'd1);
    end
    align();
    OUT_READY = 1'b1;
    chk_out(32'd1, "t5_first");
    @(negedge CLK);
    chk(OUT_DATA == 32'd2, "t5_second", OUT_DATA, 32'd2);
    chk(IN_READY == 1'b1, "t5_ready_back", 32'(IN_READY), 32'd1);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    chk_out(32'd3, "t5_third");
    @(negedge CLK);
    chk(OUT_VALID == 1'b0, "t5_drained", 32'(OUT_VALID), 32'd0);

    // Reset with both slots occupied.
    align();
    OUT_READY = 1'b0;
    send(16'hAAAA, 4'd15, 2'b00);
    send(16'h5555, 4'd15, 2'b00);
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk(OUT_VALID == 1'b0, "t6_valid", 32'(OUT_VALID), 32'd0);
    chk(OUT_DATA == 32'd0, "t6_data", OUT_DATA, 32'd0);
    chk(IN_READY == 1'b0, "t6_ready", 32'(IN_READY), 32'd0);
    #1 RESET_N = 1'b1;
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk(IN_READY == 1'b1, "t6_ready_after", 32'(IN_READY), 32'd1);
    chk(OUT_VALID == 1'b0, "t6_no_stale", 32'(OUT_VALID), 32'd0);
    chk(OUT_DATA == 32'd0, "t6_data_after", OUT_DATA, 32'd0);

    // Randomized traffic with backpressure; the producer holds until accepted.
    accepted = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!IN_VALID || accepted) begin
        IN_VALID = ($urandom_range(0, 3) != 0);
        IN_DATA  = 16'($urandom);
        SIGN_POS = 4'($urandom);
        MODE     = 2'($urandom);
      end
      if (c < 1000) OUT_READY = ($urandom_range(0, 7) != 0);
      else          OUT_READY = ($urandom_range(0, 1) != 0);
      @(negedge CLK);
      accepted = IN_VALID && IN_READY;
      @(posedge CLK);
      #1;
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    repeat (5) @(negedge CLK);
    chk(OUT_VALID == 1'b0, "final_drain", 32'(OUT_VALID), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
